// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: bundles the requester, shifter and response signals of
// shift_arbiter.
//   a_* / b_*   : requester A / B request channel (valid/ready + fields)
//   sh_*        : drive to / result from the external SHIFT32 shifter
//   resp_*      : single-entry output buffer with valid/ready and requester ID
// Modports: slave = the arbiter, master = its environment (requesters,
// shifter, consumer).
interface shift_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] a_operand;
  logic [31:0]      a_shift;
  logic             a_left;

  logic             b_valid;
  logic             b_ready;
  logic [WIDTH-1:0] b_operand;
  logic [31:0]      b_shift;
  logic             b_left;

  logic [WIDTH-1:0] sh_operand;
  logic [31:0]      sh_shift;
  logic             sh_left;
  logic [WIDTH-1:0] sh_result;

  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_id;

  modport slave (
    input  a_valid, a_operand, a_shift, a_left,
    output a_ready,
    input  b_valid, b_operand, b_shift, b_left,
    output b_ready,
    output sh_operand, sh_shift, sh_left,
    input  sh_result,
    output resp_valid, resp_data, resp_id,
    input  resp_ready
  );

  modport master (
    output a_valid, a_operand, a_shift, a_left,
    input  a_ready,
    output b_valid, b_operand, b_shift, b_left,
    input  b_ready,
    input  sh_operand, sh_shift, sh_left,
    output sh_result,
    input  resp_valid, resp_data, resp_id,
    output resp_ready
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one external combinational SHIFT32
// barrel shifter between requesters A and B. The granted request drives the
// shifter through bus.sh_*, out-of-range shift amounts force a zero result,
// and the result is registered into a single-entry output buffer tagged with
// the requester ID (0 = A, 1 = B).
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : shift_arbiter_if.slave (request, shifter and response channels)
// Optional (macro SHIFT_ARB_STATS_EN defined):
//   stat_a_cnt / stat_b_cnt : wrapping 16-bit grant counters for A / B
//   stat_stall_cnt          : wrapping 16-bit count of cycles with a request
//                             pending while the output buffer is blocked
module shift_arbiter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHAMT_BITS = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_arbiter_if.slave       bus
`ifdef SHIFT_ARB_STATS_EN
  ,
  output logic [15:0]          stat_a_cnt,
  output logic [15:0]          stat_b_cnt,
  output logic [15:0]          stat_stall_cnt
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last_grant;   // 0 = A, 1 = B
  logic [WIDTH-1:0] r_data;
  logic             r_id;

  logic             w_can_accept;
  logic             w_gnt_a;
  logic             w_gnt_b;
  logic             w_out_of_range;
  logic [WIDTH-1:0] w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Arbitration and buffer state. rst_n gates the grants so both ready
  // outputs stay low while reset is held.
  always_comb begin
    w_state_nxt  = r_state;
    w_can_accept = (r_state == S_EMPTY) || bus.resp_ready;
    w_gnt_a      = 1'b0;
    w_gnt_b      = 1'b0;
    if (rst_n && w_can_accept) begin
      if (bus.a_valid && bus.b_valid) begin
        w_gnt_a = r_last_grant;
        w_gnt_b = !r_last_grant;
      end else begin
        w_gnt_a = bus.a_valid;
        w_gnt_b = bus.b_valid;
      end
    end
    if (w_gnt_a || w_gnt_b)
      w_state_nxt = S_FULL;
    else if (r_state == S_FULL && bus.resp_ready)
      w_state_nxt = S_EMPTY;
  end

  // A's fields are the idle default so the shifter input is never X.
  always_comb begin
    bus.sh_operand = bus.a_operand;
    bus.sh_shift   = bus.a_shift;
    bus.sh_left    = bus.a_left;
    if (w_gnt_b) begin
      bus.sh_operand = bus.b_operand;
      bus.sh_shift   = bus.b_shift;
      bus.sh_left    = bus.b_left;
    end
  end

  assign w_out_of_range = |bus.sh_shift[31:SHAMT_BITS];
  assign w_capture      = w_out_of_range ? '0 : bus.sh_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= '0;
      r_id         <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_gnt_a || w_gnt_b) begin
      r_data       <= w_capture;
      r_id         <= w_gnt_b;
      r_last_grant <= w_gnt_b;
    end
  end

  assign bus.a_ready    = w_gnt_a;
  assign bus.b_ready    = w_gnt_b;
  assign bus.resp_valid = (r_state == S_FULL);
  assign bus.resp_data  = r_data;
  assign bus.resp_id    = r_id;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] r_stat_a;
  logic [15:0] r_stat_b;
  logic [15:0] r_stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_a     <= '0;
      r_stat_b     <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_gnt_a) r_stat_a <= r_stat_a + 16'd1;
      if (w_gnt_b) r_stat_b <= r_stat_b + 16'd1;
      if ((bus.a_valid || bus.b_valid) && !w_can_accept)
        r_stat_stall <= r_stat_stall + 16'd1;
    end
  end

  assign stat_a_cnt     = r_stat_a;
  assign stat_b_cnt     = r_stat_b;
  assign stat_stall_cnt = r_stat_stall;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shift_arbiter_if #(.WIDTH(32)) bus ();

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] stat_a_cnt, stat_b_cnt, stat_stall_cnt;
`endif

  shift_arbiter #(.WIDTH(32), .SHAMT_BITS(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef SHIFT_ARB_STATS_EN
    ,
    .stat_a_cnt     (stat_a_cnt),
    .stat_b_cnt     (stat_b_cnt),
    .stat_stall_cnt (stat_stall_cnt)
`endif
  );

  // External 5-bit barrel shifter: ignores the upper shift bits, so the
  // arbiter's out-of-range zeroing is visible.
  assign bus.sh_result = bus.sh_left ? (bus.sh_operand << bus.sh_shift[4:0])
                                     : (bus.sh_operand >> bus.sh_shift[4:0]);

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  bit m_full, m_last;
  bit a_acc, b_acc;
  int unsigned m_sa, m_sb, m_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [31:0] sh,
                                            input logic left);
    if (sh >= 32) return 32'd0;
    return left ? (op << sh) : (op >> sh);
  endfunction

  // Reference model: predicts grants, buffer occupancy and counters.
  always @(negedge clk) begin
    bit can, ga, gb;
    exp_t e;
    if (!rst_n) begin
      m_full = 0; m_last = 1; q.delete();
      a_acc = 0; b_acc = 0;
      m_sa = 0; m_sb = 0; m_st = 0;
      check("ready_in_reset", {30'd0, bus.a_ready, bus.b_ready}, 32'd0);
    end else begin
      can = !m_full || bus.resp_ready;
      ga  = can && bus.a_valid && (!bus.b_valid || m_last);
      gb  = can && bus.b_valid && (!bus.a_valid || !m_last);
      check("resp_valid", {31'd0, bus.resp_valid}, {31'd0, m_full});
      check("grant", {30'd0, bus.a_ready, bus.b_ready}, {30'd0, ga, gb});
      check("sh_operand", bus.sh_operand, gb ? bus.b_operand : bus.a_operand);
`ifdef SHIFT_ARB_STATS_EN
      check("stat_a", {16'd0, stat_a_cnt}, m_sa & 32'hFFFF);
      check("stat_b", {16'd0, stat_b_cnt}, m_sb & 32'hFFFF);
      check("stat_stall", {16'd0, stat_stall_cnt}, m_st & 32'hFFFF);
`endif
      if ((bus.a_valid || bus.b_valid) && !can) m_st++;
      if (ga) m_sa++;
      if (gb) m_sb++;
      if (ga || gb) begin
        e.id   = gb;
        e.data = gb ? ref_shift(bus.b_operand, bus.b_shift, bus.b_left)
                    : ref_shift(bus.a_operand, bus.a_shift, bus.a_left);
        q.push_back(e);
        m_last = gb;
        m_full = 1;
      end else if (m_full && bus.resp_ready) begin
        m_full = 0;
      end
      a_acc = ga;
      b_acc = gb;
    end
  end

  // Monitor: compares whatever the buffer presents against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.resp_valid) begin
      if (q.size() == 0) begin
        check("resp_unexpected", 32'd1, 32'd0);
      end else begin
        check("resp_data", bus.resp_data, q[0].data);
        check("resp_id", {31'd0, bus.resp_id}, {31'd0, q[0].id});
        if (bus.resp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cyc();
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_data", bus.resp_data, 32'd0);
    check("rst_resp_id", {31'd0, bus.resp_id}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic send(input bit is_b, input logic [31:0] op, input logic [31:0] sh,
                      input logic left);
    bit done = 0;
    if (is_b) begin
      bus.b_operand = op; bus.b_shift = sh; bus.b_left = left; bus.b_valid = 1'b1;
    end else begin
      bus.a_operand = op; bus.a_shift = sh; bus.a_left = left; bus.a_valid = 1'b1;
    end
    for (int i = 0; i < 50 && !done; i++) begin
      cyc();
      done = is_b ? b_acc : a_acc;
    end
    if (is_b) bus.b_valid = 1'b0;
    else      bus.a_valid = 1'b0;
    if (!done) check(is_b ? "b_accept_timeout" : "a_accept_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] oor_tab [6] = '{32'd32, 32'h0001_0000, 32'd0, 32'd31, 32'd33, 32'hFFFF_FFFF};

  initial begin
    bus.a_valid = 0; bus.a_operand = 0; bus.a_shift = 0; bus.a_left = 0;
    bus.b_valid = 0; bus.b_operand = 0; bus.b_shift = 0; bus.b_left = 0;
    bus.resp_ready = 1;
    do_reset();

    // Single A then single B.
    send(0, 32'd1, 32'd1, 1'b0);
    cyc();
    send(1, 32'd4, 32'd3, 1'b1);
    repeat (2) cyc();

    // Both continuously valid after reset: A,B,A,B with no bubbles.
    do_reset();
    bus.a_operand = 32'h8000_0000; bus.a_shift = 1; bus.a_left = 0;
    bus.b_operand = 32'd2;         bus.b_shift = 2; bus.b_left = 1;
    bus.a_valid = 1; bus.b_valid = 1; bus.resp_ready = 1;
    repeat (8) cyc();
    bus.a_valid = 0; bus.b_valid = 0;
    repeat (2) cyc();

    // Backpressure: buffer held full for 3 cycles, then drain + grant.
    bus.a_operand = 32'h1234_5678; bus.a_shift = 4; bus.a_left = 1;
    bus.a_valid = 1; bus.resp_ready = 0;
    cyc();
    repeat (3) cyc();
    check("bp_a_ready_low", {31'd0, bus.a_ready}, 32'd0);
    bus.resp_ready = 1;
    #1 check("bp_grant_on_drain", {31'd0, bus.a_ready}, 32'd1);
    cyc();
    bus.a_valid = 0;
    repeat (2) cyc();

    // Out-of-range and zero shifts, both directions.
    for (int i = 0; i < 6; i++) begin
      send(0, 32'hFFFF_FFFF, oor_tab[i], 1'b1);
      send(1, 32'hFFFF_FFFF, oor_tab[i], 1'b0);
    end
    repeat (2) cyc();

    // Randomized traffic with random consumer backpressure.
    for (int i = 0; i < 400; i++) begin
      if (!bus.a_valid || a_acc) begin
        bus.a_valid = ($urandom_range(0, 2) != 0);
        bus.a_operand = $urandom;
        bus.a_shift = ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 32);
        bus.a_left = $urandom_range(0, 1);
      end
      if (!bus.b_valid || b_acc) begin
        bus.b_valid = ($urandom_range(0, 2) != 0);
        bus.b_operand = $urandom;
        bus.b_shift = ($urandom_range(0, 4) == 0) ? $urandom : $urandom_range(0, 32);
        bus.b_left = $urandom_range(0, 1);
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    bus.a_valid = 0; bus.b_valid = 0; bus.resp_ready = 1;
    repeat (3) cyc();

    // Reset while FULL: buffer clears asynchronously, A wins first after.
    bus.a_operand = 32'd7; bus.a_shift = 1; bus.a_left = 1;
    bus.a_valid = 1; bus.resp_ready = 0;
    repeat (2) cyc();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("async_rst_resp_data", bus.resp_data, 32'd0);
    check("async_rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
`ifdef SHIFT_ARB_STATS_EN
    check("async_rst_stats", {stat_a_cnt, stat_b_cnt | stat_stall_cnt}, 32'd0);
`endif
    cyc();
    bus.b_operand = 32'd9; bus.b_shift = 2; bus.b_left = 0;
    bus.a_valid = 1; bus.b_valid = 1; bus.resp_ready = 1;
    rst_n = 1'b1;
    #1 check("first_grant_after_reset", {30'd0, bus.a_ready, bus.b_ready}, 32'd2);
    repeat (4) cyc();
    bus.a_valid = 0; bus.b_valid = 0;
    repeat (3) cyc();

    check("scoreboard_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one combinational SHIFT32 barrel shifter between two requesters (A, B), e.g. the execute-stage ALU and the address-generation path.
- Round-robin arbitration picks one requester per cycle. The controller drives the shifter, applies out-of-range shift handling and registers the result into a single-entry output buffer.
- The output buffer has a valid/ready handshake and carries a requester ID.
- The SHIFT32 instance sits outside this block and is wired through the sh_* ports.

Parameters:
- WIDTH, 32, operand/result width; must match the shifter.
- SHAMT_BITS, 5, number of low shift bits that are meaningful (log2 WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has a request.
- a_ready  out  1  A request accepted this cycle.
- a_operand  in  WIDTH  A operand.
- a_shift  in  32  A shift amount.
- a_left  in  1  A direction: 1 = left, 0 = logical right.
- b_valid, b_ready, b_operand, b_shift, b_left  same as the A ports, for requester B.
- sh_operand  out  WIDTH  to shifter operand.
- sh_shift  out  32  to shifter shift.
- sh_left  out  1  to shifter leftNotRight.
- sh_result  in  WIDTH  from shifter result (combinational).
- resp_valid  out  1  output buffer holds a result.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  WIDTH  registered result.
- resp_id  out  1  0 = A, 1 = B.

Behaviour:
- Reset (async, rst_n low):
  - resp_valid=0, resp_data=0, resp_id=0.
  - last_grant=1, so A wins first.
  - a_ready=b_ready=0 while in reset.
- Output states:
  - EMPTY (resp_valid=0) and FULL (resp_valid=1).
  - can_accept = EMPTY | (FULL & resp_ready). This allows back-to-back transfers at one result per cycle.
- Arbitration (combinational, only when can_accept):
  - Only A valid: grant A.
  - Only B valid: grant B.
  - Both valid: grant the requester not equal to last_grant.
  - a_ready/b_ready = grant, one-hot or zero; never both high.
- last_grant updates only on a granted cycle. An idle cycle does not move the pointer.
- Shifter drive:
  - sh_* carries the granted requester's fields.
  - When nothing is granted, sh_* carries A's fields. This is a don't-care but deterministic, with no X.
- Out-of-range shifts:
  - If shift[31:SHAMT_BITS] != 0, the captured result is 0 for both directions, regardless of sh_result.
  - shift==0 passes the operand unchanged.
- Capture on grant at the clock edge:
  - resp_data <= masked sh_result, resp_id <= granted ID, resp_valid <= 1.
- Drain without grant (FULL & resp_ready, no request):
  - resp_valid <= 0; resp_data and resp_id hold their values.
- FULL & !resp_ready:
  - No grant. resp_data and resp_id are stable.
  - Requesters must hold valid and their fields until they see ready.
- Latency: 1 cycle from a_ready/b_ready high to resp_valid for that result.
- Fairness: with both requesters continuously valid and resp_ready=1, grants alternate A,B,A,B.
- Reset mid-operation clears the output buffer immediately; a pending result is lost. The first grant after reset goes to A.

Optional Feature:
- Macro: SHIFT_ARB_STATS_EN.
- With the macro defined:
  - Adds outputs stat_a_cnt[15:0], stat_b_cnt[15:0] and stat_stall_cnt[15:0].
  - stat_a_cnt / stat_b_cnt increment per grant to A / B.
  - stat_stall_cnt increments on each cycle where any request is valid but no grant is given, i.e. output FULL with resp_ready=0.
  - All counters wrap at 16'hFFFF -> 0 and reset to 0 on rst_n.
- Without the macro: these ports and counters do not exist, and the remaining behaviour is identical.

Test Plan:
- Single A request: operand=1, shift=1, left=0 -> a_ready=1 in cycle 0. Cycle 1: resp_valid=1, resp_data=0, resp_id=0.
- Single B request: operand=4, shift=3, left=1 -> next cycle resp_data=32, resp_id=1.
- Both valid continuously, resp_ready=1:
  - A: 32'h8000_0000 >> 1; B: 2 << 2.
  - Grant order after reset is A,B,A,B.
  - resp_data alternates 32'h4000_0000 and 8, with no bubbles.
- Backpressure:
  - Hold resp_ready=0 for 3 cycles with A valid.
  - Result stays stable and a_ready stays 0 throughout.
  - Raise resp_ready: the buffer drains and A is granted the same cycle.
- Out-of-range shift: operand=32'hFFFF_FFFF, shift=32 (and shift=32'h0001_0000), left=1 -> resp_data=0. shift=0 -> resp_data=32'hFFFF_FFFF.
- Reset mid-operation: assert rst_n=0 while FULL -> resp_valid drops asynchronously. After release with both valid, A is granted first. With SHIFT_ARB_STATS_EN defined, the counters read 0.
